// File: rtl/cd_tx_sched.sv
// rtl/cd_tx_sched.sv - round-robin two-source frame scheduler into the CDBUS TX page
module cd_tx_sched #(
  parameter logic [3:0]  ADDR_STATUS = 4'd2,
  parameter logic [4:0]  PEND_BIT    = 5'd1,
  parameter logic [3:0]  ADDR_CMD    = 4'd5,
  parameter logic [31:0] CMD_SWITCH  = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rq_valid,
  input  logic [15:0] rq_data,
  input  logic [1:0]  rq_last,
  output logic [1:0]  rq_ready,
  output logic [3:0]  csr_address,
  output logic [3:0]  csr_byteenable,
  output logic        csr_read,
  input  logic [31:0] csr_readdata,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  output logic [5:0]  tx_mm_address,
  output logic [3:0]  tx_mm_byteenable,
  output logic        tx_mm_write,
  output logic [31:0] tx_mm_writedata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        frame_done,
  output logic        err_trunc
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_POLL_RD, S_POLL_CHK, S_SWITCH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_grant;
  logic        r_rr_last;     // requester granted most recently
  logic [8:0]  r_cnt;         // bytes stored for the current frame, saturates at 256
  logic [31:0] r_word;
  logic        r_trunc;
  logic        r_last_seen;

  logic        w_gidx;
  logic [7:0]  w_byte;
  logic        w_lastb;
  logic        w_acc;
  logic        w_disc;
  logic        w_pick;
  logic        w_pend;

  assign w_gidx  = r_grant[1];
  assign w_byte  = w_gidx ? rq_data[15:8] : rq_data[7:0];
  assign w_lastb = w_gidx ? rq_last[1] : rq_last[0];
  assign w_acc   = (r_state == S_FILL) && rq_valid[w_gidx];
  assign w_disc  = r_cnt[8];
  // With both requesting, the one not served last goes next.
  assign w_pick  = (rq_valid == 2'b11) ? ~r_rr_last : rq_valid[1];
  assign w_pend  = |(csr_readdata & (32'd1 << PEND_BIT));
  assign grant   = r_grant;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and bus strobes.
  always_comb begin
    w_next           = r_state;
    rq_ready         = 2'b00;
    csr_address      = 4'd0;
    csr_byteenable   = 4'h0;
    csr_read         = 1'b0;
    csr_write        = 1'b0;
    csr_writedata    = 32'd0;
    tx_mm_address    = 6'd0;
    tx_mm_byteenable = 4'h0;
    tx_mm_write      = 1'b0;
    tx_mm_writedata  = 32'd0;
    busy             = (r_state != S_IDLE);
    frame_done       = 1'b0;
    err_trunc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|rq_valid) w_next = S_FILL;
      end
      S_FILL: begin
        rq_ready = r_grant;
        if (w_acc) begin
          if (w_disc) begin
            if (w_lastb) w_next = S_POLL_RD;
          end else if (w_lastb || (r_cnt[1:0] == 2'd3)) begin
            w_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        tx_mm_write     = 1'b1;
        tx_mm_address   = 6'((r_cnt - 9'd1) >> 2);
        tx_mm_writedata = r_word;
        case (r_cnt[1:0])
          2'd1:    tx_mm_byteenable = 4'h1;
          2'd2:    tx_mm_byteenable = 4'h3;
          2'd3:    tx_mm_byteenable = 4'h7;
          default: tx_mm_byteenable = 4'hf;
        endcase
        w_next = r_last_seen ? S_POLL_RD : S_FILL;
      end
      S_POLL_RD: begin
        csr_read       = 1'b1;
        csr_address    = ADDR_STATUS;
        csr_byteenable = 4'hf;
        w_next         = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        w_next = w_pend ? S_POLL_RD : S_SWITCH;
      end
      S_SWITCH: begin
        csr_write      = 1'b1;
        csr_address    = ADDR_CMD;
        csr_byteenable = 4'hf;
        csr_writedata  = CMD_SWITCH;
        frame_done     = 1'b1;
        err_trunc      = r_trunc;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant, byte packing and per-frame bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant     <= 2'b00;
      r_rr_last   <= 1'b1;
      r_cnt       <= 9'd0;
      r_word      <= 32'd0;
      r_trunc     <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|rq_valid) r_grant <= w_pick ? 2'b10 : 2'b01;
        end
        S_FILL: begin
          if (w_acc) begin
            if (w_disc) begin
              r_trunc <= 1'b1;
            end else begin
              r_word[{r_cnt[1:0], 3'b000} +: 8] <= w_byte;
              r_cnt <= r_cnt + 9'd1;
            end
            if (w_lastb) r_last_seen <= 1'b1;
          end
        end
        S_WRITE: begin
          r_word <= 32'd0;
        end
        S_SWITCH: begin
          r_rr_last   <= w_gidx;
          r_grant     <= 2'b00;
          r_cnt       <= 9'd0;
          r_trunc     <= 1'b0;
          r_last_seen <= 1'b0;
          r_word      <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_tx_sched.sv
// tb/tb_cd_tx_sched.sv - randomized and directed bench for cd_tx_sched against a frame-level model
module tb_cd_tx_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  rq_valid;
  logic [15:0] rq_data;
  logic [1:0]  rq_last;
  logic [1:0]  rq_ready;
  logic [3:0]  csr_address;
  logic [3:0]  csr_byteenable;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [5:0]  tx_mm_address;
  logic [3:0]  tx_mm_byteenable;
  logic        tx_mm_write;
  logic [31:0] tx_mm_writedata;
  logic [1:0]  grant;
  logic        busy;
  logic        frame_done;
  logic        err_trunc;

  cd_tx_sched dut (
    .clk(clk), .reset_n(reset_n),
    .rq_valid(rq_valid), .rq_data(rq_data), .rq_last(rq_last), .rq_ready(rq_ready),
    .csr_address(csr_address), .csr_byteenable(csr_byteenable), .csr_read(csr_read),
    .csr_readdata(csr_readdata), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .tx_mm_address(tx_mm_address), .tx_mm_byteenable(tx_mm_byteenable),
    .tx_mm_write(tx_mm_write), .tx_mm_writedata(tx_mm_writedata),
    .grant(grant), .busy(busy), .frame_done(frame_done), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame sources
  logic [7:0] src_buf [2][512];
  int  src_len [2];
  int  src_pos [2];
  bit  src_act [2];
  bit  fv_seen [2];
  int  fv_cyc  [2];
  int  valid_pct = 100;
  bit  scripted = 1'b1;
  int  ones_left = 0;

  task automatic load_src(input int s, input int len, input logic [7:0] first,
                          input logic [7:0] step, input bit rnd);
    for (int k = 0; k < len; k++)
      src_buf[s][k] = rnd ? 8'($urandom) : 8'(first + step * k);
    src_len[s] = len;
    src_pos[s] = 0;
    fv_seen[s] = 1'b0;
    src_act[s] = 1'b1;
  endtask

  // Frame-level model
  typedef struct {
    logic [5:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t expq[$];
  bit  exp_trunc;
  int  cur = -1;
  int  last_served = -1;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] prev_valid = 2'b00;
  bit  prev_done = 1'b0;
  bit  prev_read = 1'b0;
  int  reads = 0;
  int  ones = 0;
  bit  last_resp = 1'b1;

  logic [5:0]  wl_a [$];
  logic [3:0]  wl_be[$];
  logic [31:0] wl_d [$];
  logic [1:0]  gl   [$];
  int  n_done = 0;
  int  sw_cyc = 0;
  int  d_reads = 0;
  bit  d_trunc = 1'b0;

  // A frame of L bytes becomes ceil(min(L,256)/4) little-endian words at 0,1,2,...
  function automatic void build(input int s);
    int n;
    int lanes;
    wr_t e;
    n = (src_len[s] > 256) ? 256 : src_len[s];
    exp_trunc = (src_len[s] > 256);
    expq.delete();
    for (int w = 0; 4 * w < n; w++) begin
      lanes = (n - 4 * w > 4) ? 4 : n - 4 * w;
      e.a = 6'(w);
      e.d = 32'd0;
      for (int b = 0; b < lanes; b++) e.d[8 * b +: 8] = src_buf[s][4 * w + b];
      e.be = 4'((1 << lanes) - 1);
      expq.push_back(e);
    end
  endfunction

  task automatic clear_logs();
    wl_a.delete(); wl_be.delete(); wl_d.delete(); gl.delete();
  endtask

  // Source and status-register driver
  initial begin : driver
    logic [1:0] acc;
    logic rd;
    logic pend;
    rq_valid = 2'b00; rq_data = 16'd0; rq_last = 2'b00; csr_readdata = 32'd0;
    forever begin
      @(negedge clk);
      acc = rq_valid & rq_ready;
      rd  = csr_read;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && src_act[i]) begin
          src_pos[i]++;
          if (src_pos[i] >= src_len[i]) src_act[i] = 1'b0;
        end
      end
      csr_readdata = $urandom;
      if (rd) begin
        pend = scripted ? (ones_left > 0) : ($urandom_range(2) == 0);
        if (scripted && ones_left > 0) ones_left--;
        csr_readdata[1] = pend;
      end
      for (int i = 0; i < 2; i++) begin
        if (src_act[i] && $urandom_range(99) < valid_pct) begin
          rq_valid[i] = 1'b1;
          rq_data[8 * i +: 8] = src_buf[i][src_pos[i]];
          rq_last[i] = (src_pos[i] == src_len[i] - 1);
          if (!fv_seen[i]) begin
            fv_seen[i] = 1'b1;
            fv_cyc[i] = cyc;
          end
        end else begin
          rq_valid[i] = 1'b0;
          rq_data[8 * i +: 8] = 8'($urandom);
          rq_last[i] = 1'($urandom_range(1));
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin : compare
    logic [1:0] eg;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        expq.delete();
        cur = -1; last_served = -1;
        prev_grant = 2'b00; prev_valid = rq_valid;
        prev_done = 1'b0; prev_read = 1'b0;
        reads = 0; ones = 0; last_resp = 1'b1;
      end else begin
        if (prev_grant != 2'b00)      eg = prev_done ? 2'b00 : prev_grant;
        else if (prev_valid == 2'b11) eg = (last_served == 0) ? 2'b10 : 2'b01;
        else                          eg = prev_valid;
        chk("grant", grant, eg);
        chk("busy", busy, 64'(grant != 2'b00));
        chk("ready_owner", rq_ready & ~grant, 0);
        chk("one_strobe", 64'($countones({csr_read, csr_write, tx_mm_write}) <= 1), 1);
        chk("csr_be", csr_byteenable, (csr_read || csr_write) ? 4'hf : 4'h0);
        chk("done_with_write", frame_done, csr_write);
        if (!frame_done) chk("trunc_quiet", err_trunc, 0);
        if (prev_grant == 2'b00 && grant != 2'b00) begin
          cur = grant[1] ? 1 : 0;
          build(cur);
          reads = 0; ones = 0; last_resp = 1'b1;
          gl.push_back(grant);
        end
        if (prev_read) begin
          last_resp = csr_readdata[1];
          if (last_resp) ones++;
        end
        if (tx_mm_write) begin
          chk("tx_expected", 64'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tx_addr", tx_mm_address, e.a);
            chk("tx_be", tx_mm_byteenable, e.be);
            chk("tx_data", tx_mm_writedata, e.d);
          end
          wl_a.push_back(tx_mm_address);
          wl_be.push_back(tx_mm_byteenable);
          wl_d.push_back(tx_mm_writedata);
        end
        if (csr_read) begin
          chk("rd_addr", csr_address, 4'd2);
          chk("rd_after_writes", expq.size(), 0);
          reads++;
        end
        if (csr_write) begin
          chk("sw_addr", csr_address, 4'd5);
          chk("sw_data", csr_writedata, 32'h2);
          chk("sw_trunc", err_trunc, exp_trunc);
          chk("sw_all_written", expq.size(), 0);
          chk("sw_polls", reads, ones + 1);
          chk("sw_last_poll", last_resp, 0);
          n_done++;
          sw_cyc = cyc;
          d_reads = reads;
          d_trunc = err_trunc;
          last_served = cur;
        end
        prev_grant = grant;
        prev_valid = rq_valid;
        prev_done  = frame_done;
        prev_read  = csr_read;
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("done_in_time", 64'(n_done >= target), 1);
  endtask

  task automatic check_quiet(input string name);
    chk(name, 64'(|{rq_ready, csr_address, csr_byteenable, csr_read, csr_write, csr_writedata,
                     tx_mm_address, tx_mm_byteenable, tx_mm_write, tx_mm_writedata,
                     grant, busy, frame_done, err_trunc}), 0);
  endtask

  initial begin : test
    int base;
    int k;
    int bad;
    int issued;
    int len;
    src_act[0] = 1'b0; src_act[1] = 1'b0;
    src_len[0] = 1; src_len[1] = 1; src_pos[0] = 0; src_pos[1] = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset_outputs");
    #2 reset_n = 1'b1;

    // Five-byte frame from requester 0
    @(negedge clk);
    clear_logs();
    scripted = 1'b1; ones_left = 0; valid_pct = 100;
    base = n_done;
    load_src(0, 5, 8'h11, 8'h11, 1'b0);
    wait_done(base + 1, 200);
    chk("t1_nwrites", wl_a.size(), 2);
    if (wl_a.size() >= 2) begin
      chk("t1_w0_data", wl_d[0], 32'h44332211);
      chk("t1_w0_addr", wl_a[0], 0);
      chk("t1_w0_be", wl_be[0], 4'hf);
      chk("t1_w1_data", wl_d[1], 32'h00000055);
      chk("t1_w1_addr", wl_a[1], 1);
      chk("t1_w1_be", wl_be[1], 4'h1);
    end
    chk("t1_reads", d_reads, 1);
    chk("t1_trunc", d_trunc, 0);
    chk("t1_latency", sw_cyc - fv_cyc[0], 10);

    // Both requesting at reset exit
    @(negedge clk);
    reset_n = 1'b0;
    clear_logs();
    load_src(0, 4, 8'ha0, 8'h01, 1'b0);
    load_src(1, 4, 8'hb0, 8'h01, 1'b0);
    base = n_done;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    wait_done(base + 2, 200);
    chk("t2_ngrants", gl.size(), 2);
    if (gl.size() >= 2) begin
      chk("t2_g0", gl[0], 2'b01);
      chk("t2_g1", gl[1], 2'b10);
    end
    if (wl_d.size() >= 2) begin
      chk("t2_d0", wl_d[0], 32'ha3a2a1a0);
      chk("t2_d1", wl_d[1], 32'hb3b2b1b0);
    end

    // Contended alternation: req0, req1, req0
    @(negedge clk);
    clear_logs();
    base = n_done;
    load_src(0, 4, 8'hc0, 8'h01, 1'b0);
    load_src(1, 4, 8'hd0, 8'h01, 1'b0);
    k = 0;
    while (src_act[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    load_src(0, 4, 8'he0, 8'h01, 1'b0);
    wait_done(base + 3, 300);
    chk("t3_ngrants", gl.size(), 3);
    if (gl.size() >= 3) begin
      chk("t3_g0", gl[0], 2'b01);
      chk("t3_g1", gl[1], 2'b10);
      chk("t3_g2", gl[2], 2'b01);
    end
    if (wl_d.size() >= 3) begin
      chk("t3_d0", wl_d[0], 32'hc3c2c1c0);
      chk("t3_d1", wl_d[1], 32'hd3d2d1d0);
      chk("t3_d2", wl_d[2], 32'he3e2e1e0);
    end

    // Status reports pending three times
    @(negedge clk);
    clear_logs();
    base = n_done;
    ones_left = 3;
    load_src(1, 2, 8'h5a, 8'h01, 1'b0);
    wait_done(base + 1, 200);
    chk("t4_reads", d_reads, 4);
    chk("t4_latency", sw_cyc - fv_cyc[1], 12);

    // 300, 256 and 257 byte frames
    @(negedge clk);
    clear_logs();
    base = n_done;
    load_src(0, 300, 8'h00, 8'h00, 1'b1);
    wait_done(base + 1, 1000);
    chk("t5_nwrites", wl_a.size(), 64);
    bad = 0;
    for (int i = 0; i < wl_a.size(); i++) if (wl_a[i] != 6'(i)) bad++;
    chk("t5_addr_order", bad, 0);
    chk("t5_trunc", d_trunc, 1);
    chk("t5_all_accepted", src_pos[0], 300);
    @(negedge clk);
    clear_logs();
    load_src(1, 256, 8'h00, 8'h00, 1'b1);
    wait_done(base + 2, 1000);
    chk("t5_256_nwrites", wl_a.size(), 64);
    chk("t5_256_trunc", d_trunc, 0);
    @(negedge clk);
    clear_logs();
    load_src(0, 257, 8'h00, 8'h00, 1'b1);
    wait_done(base + 3, 1000);
    chk("t5_257_nwrites", wl_a.size(), 64);
    chk("t5_257_trunc", d_trunc, 1);

    // Reset in the middle of FILL
    @(negedge clk);
    clear_logs();
    load_src(0, 10, 8'h70, 8'h01, 1'b0);
    k = 0;
    while (src_pos[0] < 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    base = n_done;
    #2 reset_n = 1'b0;
    src_act[0] = 1'b0; src_act[1] = 1'b0;
    #1 check_quiet("t6_async_reset");
    repeat (3) @(negedge clk);
    chk("t6_no_switch", n_done, base);
    #2 reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
    load_src(0, 3, 8'h01, 8'h01, 1'b0);
    wait_done(base + 1, 200);
    if (wl_a.size() >= 1) begin
      chk("t6_restart_addr", wl_a[0], 0);
      chk("t6_restart_data", wl_d[0], 32'h00030201);
      chk("t6_restart_be", wl_be[0], 4'h7);
    end

    // Randomized traffic
    scripted = 1'b0;
    issued = 0;
    base = n_done;
    k = 0;
    while (issued < 60 && k < 30000) begin
      @(negedge clk);
      k++;
      for (int s = 0; s < 2; s++) begin
        if (!src_act[s] && issued < 60 && $urandom_range(3) == 0) begin
          len = ($urandom_range(9) == 0) ? int'($urandom_range(300, 250)) : int'($urandom_range(12, 1));
          load_src(s, len, 8'h00, 8'h00, 1'b1);
          issued++;
        end
      end
      if ($urandom_range(15) == 0) valid_pct = int'($urandom_range(100, 40));
    end
    wait_done(base + issued, 30000);
    chk("rand_frames", n_done - base, issued);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
